// File: rtl/bka_stream_accumulator_pkg.sv
// Shared types and helpers for the Brent-Kung stream accumulator.
// Widths, state encoding and the saturating counter step.
package bka_stream_accumulator_pkg;

  localparam int W  = 25;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  // {clamped, next}: the top bit flags an increment lost at the ceiling
  function automatic logic [CW:0] sat_inc(
    input logic [CW-1:0] v,
    input logic          inc
  );
    logic [CW:0] r;
    if (inc && (v == {CW{1'b1}}))
      r = {1'b1, v};
    else
      r = {1'b0, v + CW'(inc)};
    return r;
  endfunction

endpackage

// File: rtl/UBBKA_24_0_24_0.sv
// 25-bit unsigned Brent-Kung adder core, X[24:0] + Y[24:0] -> S[25:0].
// Carry-in is tied to zero; S[25] is the carry-out.
module UBBKA_24_0_24_0 (
  output logic [25:0] S,
  input  logic [24:0] X,
  input  logic [24:0] Y
);

  function automatic logic [25:0] bk_add(
    input logic [24:0] x,
    input logic [24:0] y
  );
    logic [24:0] g;
    logic [24:0] p;
    logic [24:0] h;
    logic [25:0] s;
    g = x & y;
    p = x ^ y;
    h = p;
    // up-sweep: group nodes at power-of-two strides
    for (int d = 1; d < 32; d = d * 2) begin
      for (int i = 0; i < 25; i++) begin
        if (((i + 1) % (2 * d)) == 0) begin
          g[5'(i)] = g[5'(i)] | (p[5'(i)] & g[5'(i - d)]);
          p[5'(i)] = p[5'(i)] & p[5'(i - d)];
        end
      end
    end
    // down-sweep: fill the remaining prefixes
    for (int d = 8; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < 25; i = i + 2 * d) begin
        g[5'(i)] = g[5'(i)] | (p[5'(i)] & g[5'(i - d)]);
        p[5'(i)] = p[5'(i)] & p[5'(i - d)];
      end
    end
    s[0] = h[0];
    for (int i = 1; i < 25; i++)
      s[5'(i)] = h[5'(i)] ^ g[5'(i - 1)];
    s[25] = g[24];
    return s;
  endfunction

  assign S = bk_add(X, Y);

endmodule

// File: rtl/bka_stream_accumulator.sv
// Packet accumulator around the Brent-Kung adder core.
// One {carry, sum} result per packet on a valid/ready output.
module bka_stream_accumulator
  import bka_stream_accumulator_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_V,
  output logic            IN_RDY,
  input  logic [W-1:0]    IN_D,
  input  logic            IN_LAST,
  output logic            OUT_V,
  input  logic            OUT_RDY,
  output logic [W+CW-1:0] OUT_SUM,
  output logic [CW-1:0]   OUT_CNT,
  output logic            OUT_OVF
);

  state_t        state;
  logic [W-1:0]  acc;
  logic [CW-1:0] carry;
  logic [CW-1:0] wcnt;
  logic          ovf;

  logic [W-1:0]  x;
  logic [W:0]    s;
  logic [CW:0]   carry_inc;
  logic [CW:0]   wcnt_inc;
  logic          ovf_n;
  logic          accept;

  assign x = (state == ST_ACC) ? acc : '0;

  UBBKA_24_0_24_0 u_bka (
    .S (s),
    .X (x),
    .Y (IN_D)
  );

  assign carry_inc = sat_inc(carry, s[W]);
  assign wcnt_inc  = sat_inc(wcnt, 1'b1);
  assign ovf_n     = ovf | carry_inc[CW] | wcnt_inc[CW];

  assign IN_RDY = (state != ST_DONE) | OUT_RDY;
  assign OUT_V  = (state == ST_DONE);
  assign accept = IN_V & IN_RDY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      acc     <= '0;
      carry   <= '0;
      wcnt    <= '0;
      ovf     <= 1'b0;
      OUT_SUM <= '0;
      OUT_CNT <= '0;
      OUT_OVF <= 1'b0;
    end else if (accept && IN_LAST) begin
      state   <= ST_DONE;
      OUT_SUM <= {carry_inc[CW-1:0], s[W-1:0]};
      OUT_CNT <= wcnt_inc[CW-1:0];
      OUT_OVF <= ovf_n;
      acc     <= '0;
      carry   <= '0;
      wcnt    <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      state <= ST_ACC;
      acc   <= s[W-1:0];
      carry <= carry_inc[CW-1:0];
      wcnt  <= wcnt_inc[CW-1:0];
      ovf   <= ovf_n;
    end else if (state == ST_DONE && OUT_RDY) begin
      state <= ST_IDLE;
    end
  end

endmodule
